// File: rtl/robot_pkg.sv
// Shared command and wheel codes for the two-wheel drive controller.
// Combinational definitions only; no latency.
// No flow control: constants and types only.
package robot_pkg;

    localparam logic [2:0] STAY1         = 3'b000;
    localparam logic [2:0] STAY2         = 3'b100;
    localparam logic [2:0] MOVE_FORWARD  = 3'b111;
    localparam logic [2:0] TURN_LEFT1    = 3'b101;
    localparam logic [2:0] TURN_LEFT2    = 3'b010;
    localparam logic [2:0] TURN_RIGHT1   = 3'b110;
    localparam logic [2:0] MOVE_BACKWARD = 3'b011;

    localparam logic [1:0] WHL_STOP = 2'b00;
    localparam logic [1:0] WHL_FWD  = 2'b01;
    localparam logic [1:0] WHL_REV  = 2'b10;

    typedef enum logic {
        OFF = 1'b0,
        ON  = 1'b1
    } state_t;

endpackage

// File: rtl/robot_cmd_decoder.sv
// Maps a motion command to per-wheel drive codes plus a forward flag.
// Purely combinational, zero latency.
// No backpressure; output follows input continuously.
module robot_cmd_decoder
    import robot_pkg::*;
(
    input  logic [2:0] move,
    output logic [1:0] left_code,
    output logic [1:0] right_code,
    output logic       is_forward
);

    always_comb begin
        left_code  = WHL_STOP;
        right_code = WHL_STOP;
        is_forward = 1'b0;
        case (move)
            MOVE_FORWARD: begin
                left_code  = WHL_FWD;
                right_code = WHL_FWD;
                is_forward = 1'b1;
            end
            MOVE_BACKWARD: begin
                left_code  = WHL_REV;
                right_code = WHL_REV;
            end
            TURN_RIGHT1: begin
                left_code  = WHL_FWD;
                right_code = WHL_REV;
            end
            TURN_LEFT1, TURN_LEFT2: begin
                left_code  = WHL_REV;
                right_code = WHL_FWD;
            end
            // STAY1, STAY2 and the unused 001 all hold the wheels stopped
            default: begin
                left_code  = WHL_STOP;
                right_code = WHL_STOP;
            end
        endcase
    end

endmodule

// File: rtl/robot_ctrl.sv
// Two-wheel drive controller: power FSM, obstacle gating, registered outputs.
// One cycle from inputs to every output; reset clears outputs asynchronously.
// No backpressure: a new command is accepted on every clock edge.
module robot_ctrl
    import robot_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       motor_on_i,
    input  logic [2:0] move_i,
    input  logic       tracker_fwrd_i,
    output logic       motor_status_o,
    output logic       tracker_status_o,
    output logic [1:0] left_motor_o,
    output logic [1:0] right_motor_o
);

    state_t     state;
    state_t     next_state;
    logic [1:0] dec_left;
    logic [1:0] dec_right;
    logic       dec_is_fwd;
    logic [1:0] left_nxt;
    logic [1:0] right_nxt;

    robot_cmd_decoder u_decoder (
        .move       (move_i),
        .left_code  (dec_left),
        .right_code (dec_right),
        .is_forward (dec_is_fwd)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= OFF;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            OFF:     if (motor_on_i)  next_state = ON;
            ON:      if (!motor_on_i) next_state = OFF;
            default: next_state = OFF;
        endcase
    end

    // Gating uses the live enable so power-on and power-off both take effect
    // on the edge where the enable is sampled, not one cycle later.
    always_comb begin
        left_nxt  = dec_left;
        right_nxt = dec_right;
        if (!motor_on_i || (dec_is_fwd && tracker_fwrd_i)) begin
            left_nxt  = WHL_STOP;
            right_nxt = WHL_STOP;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            left_motor_o     <= WHL_STOP;
            right_motor_o    <= WHL_STOP;
            tracker_status_o <= 1'b0;
        end else begin
            left_motor_o     <= left_nxt;
            right_motor_o    <= right_nxt;
            tracker_status_o <= tracker_fwrd_i;
        end
    end

    assign motor_status_o = (state == ON);

endmodule

// File: tb/tb_robot_ctrl.sv
// Directed bench for robot_ctrl with hand-computed expected wheel codes.
module tb_robot_ctrl;

    logic       clk;
    logic       rst;
    logic       motor_on;
    logic [2:0] move;
    logic       tracker_fwrd;
    logic       motor_status;
    logic       tracker_status;
    logic [1:0] left_motor;
    logic [1:0] right_motor;

    int checks = 0;
    int errors = 0;

    // {left,right} for move codes 000..111
    logic [3:0] exp_tab [0:7];
    logic [2:0] pulse_cmd [0:4];
    logic [3:0] pulse_exp [0:4];

    robot_ctrl dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .motor_on_i       (motor_on),
        .move_i           (move),
        .tracker_fwrd_i   (tracker_fwrd),
        .motor_status_o   (motor_status),
        .tracker_status_o (tracker_status),
        .left_motor_o     (left_motor),
        .right_motor_o    (right_motor)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        exp_tab = '{4'b0000, 4'b0000, 4'b1001, 4'b1010,
                    4'b0000, 4'b1001, 4'b0110, 4'b0101};
        pulse_cmd = '{3'b111, 3'b011, 3'b110, 3'b101, 3'b010};
        pulse_exp = '{4'b0101, 4'b1010, 4'b0110, 4'b1001, 4'b1001};

        rst          = 1'b1;
        motor_on     = 1'b0;
        move         = 3'b000;
        tracker_fwrd = 1'b0;
        step();
        step();
        check_val("reset_outputs", {2'b00, motor_status, tracker_status, left_motor, right_motor}, 8'h00);
        rst = 1'b0;

        // Power on with stay commands
        motor_on = 1'b1;
        step();
        check_val("pwr_on_status", {7'b0, motor_status}, 8'h01);
        check_val("pwr_on_wheels", {4'b0, left_motor, right_motor}, 8'h00);
        step();
        step();
        check_val("pwr_on_hold", {3'b0, motor_status, left_motor, right_motor}, 8'h10);

        // One-cycle pulses for each motion command
        for (int i = 0; i < 5; i++) begin
            move = pulse_cmd[i];
            step();
            check_val($sformatf("pulse_%0d", i), {4'b0, left_motor, right_motor}, {4'b0, pulse_exp[i]});
            move = 3'b000;
            step();
            check_val($sformatf("pulse_end_%0d", i), {4'b0, left_motor, right_motor}, 8'h00);
        end

        // Obstacle blocks forward only
        tracker_fwrd = 1'b1;
        move = 3'b111;
        step();
        check_val("obst_status", {7'b0, tracker_status}, 8'h01);
        check_val("obst_fwd_blocked", {4'b0, left_motor, right_motor}, 8'h00);
        move = 3'b110;
        step();
        check_val("obst_turn_ok", {4'b0, left_motor, right_motor}, 8'h06);
        move = 3'b011;
        step();
        check_val("obst_back_ok", {4'b0, left_motor, right_motor}, 8'h0A);
        tracker_fwrd = 1'b0;
        move = 3'b000;
        step();
        check_val("obst_clear", {6'b0, tracker_status, motor_status}, 8'h01);

        // Power off overrides a forward command
        motor_on = 1'b0;
        move = 3'b111;
        step();
        check_val("pwr_off", {3'b0, motor_status, left_motor, right_motor}, 8'h00);
        move = 3'b011;
        step();
        check_val("pwr_off_ignore", {3'b0, motor_status, left_motor, right_motor}, 8'h00);

        // Power-on edge executes the command present on it
        motor_on = 1'b1;
        move = 3'b111;
        step();
        check_val("pwr_on_same_edge", {3'b0, motor_status, left_motor, right_motor}, 8'h15);

        // Asynchronous reset mid-pulse
        #2;
        rst = 1'b1;
        #1;
        check_val("async_reset", {2'b00, motor_status, tracker_status, left_motor, right_motor}, 8'h00);
        motor_on = 1'b0;
        move = 3'b000;
        step();
        check_val("reset_held", {2'b00, motor_status, tracker_status, left_motor, right_motor}, 8'h00);
        rst = 1'b0;
        step();
        check_val("post_reset_off", {7'b0, motor_status}, 8'h00);
        motor_on = 1'b1;
        step();
        check_val("post_reset_on", {7'b0, motor_status}, 8'h01);

        // Full decode sweep
        for (int c = 0; c < 8; c++) begin
            move = c[2:0];
            step();
            check_val($sformatf("sweep_%0d", c), {4'b0, left_motor, right_motor}, {4'b0, exp_tab[c]});
            check_val($sformatf("no_code11_%0d", c),
                      {7'b0, (left_motor == 2'b11) || (right_motor == 2'b11)}, 8'h00);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
